// File: rtl/bcd_pkg.sv
// Shared types and helpers for the packed-BCD counter.
//   bcd_digit_t : one 4-bit BCD digit
//   BCD_MAX     : largest legal digit value (9)
//   is_bcd()    : 1 when a digit is in 0..9, used to validate parallel loads
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One stage of the BCD ripple chain. Computes the next value of a single digit
// and whether the step propagates to the next more-significant digit.
//   d        in  4  current digit value (0..9)
//   up       in  1  1 = increment, 0 = decrement
//   step_in  in  1  this digit moves this cycle (all lower digits at 9 / 0)
//   d_next   out 4  digit value after the step (unchanged when step_in = 0)
//   step_out out 1  carry/borrow into the next digit
module bcd_digit_step
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    input  logic       up,
    input  logic       step_in,
    output logic [3:0] d_next,
    output logic       step_out
);

    logic at_limit;

    // The digit rolls over when it sits at the edge of 0..9 in the count direction.
    assign at_limit = up ? (d == BCD_MAX) : (d == 4'd0);
    assign step_out = step_in & at_limit;

    always_comb begin
        d_next = d;
        if (step_in) begin
            if (up) begin
                d_next = at_limit ? 4'd0 : d + 4'd1;
            end else begin
                d_next = at_limit ? BCD_MAX : d - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_counter.sv
// Registered N-digit packed-BCD up/down counter with synchronous clear,
// validated parallel load, wrap/saturate at the terminal value and a
// terminal-count pulse.
//   clk       in  1            rising-edge clock
//   reset_n   in  1            asynchronous active-low reset
//   clr       in  1            synchronous clear (highest priority)
//   load      in  1            synchronous load of load_val if all digits are BCD
//   load_val  in  4*N_DIGITS   packed BCD load value, digit 0 in [3:0]
//   en        in  1            count enable, one step per cycle
//   up        in  1            1 = increment, 0 = decrement
//   sat       in  1            1 = hold at terminal value, 0 = wrap
//   count     out 4*N_DIGITS   registered packed BCD count
//   tc        out 1            registered pulse: enabled step at terminal value
//   load_err  out 1            registered pulse: load rejected (non-BCD digit)
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] load_val,
    input  logic                  en,
    input  logic                  up,
    input  logic                  sat,
    output logic [4*N_DIGITS-1:0] count,
    output logic                  tc,
    output logic                  load_err
);

    logic [N_DIGITS:0]       step;
    logic [4*N_DIGITS-1:0]   count_next;
    logic                    terminal;
    logic                    load_ok;

    // Digit 0 always steps; each higher digit steps only when every digit
    // below it is at its rollover value, so step[N_DIGITS] marks all-9s
    // (up) or all-0s (down).
    assign step[0] = 1'b1;

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        bcd_digit_step u_step (
            .d        (count[4*i +: 4]),
            .up       (up),
            .step_in  (step[i]),
            .d_next   (count_next[4*i +: 4]),
            .step_out (step[i+1])
        );
    end

    assign terminal = step[N_DIGITS];

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!is_bcd(load_val[4*i +: 4])) begin
                load_ok = 1'b0;
            end
        end
    end

    // Priority clr > load > en. At the terminal value the chain's natural
    // next value is already the wrapped one; saturation simply skips the update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else if (clr) begin
            count    <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            tc <= 1'b0;
            if (load_ok) begin
                count    <= load_val;
                load_err <= 1'b0;
            end else begin
                load_err <= 1'b1;
            end
        end else begin
            load_err <= 1'b0;
            if (en) begin
                tc <= terminal;
                if (!(terminal && sat)) begin
                    count <= count_next;
                end
            end else begin
                tc <= 1'b0;
            end
        end
    end

endmodule
